// File: rtl/uart_rx_monitor_pkg.sv
// Shared types and constants for the multi-channel UART receive monitor.
package uart_rx_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned ERR_FRAME  = 0;
    localparam int unsigned ERR_PARITY = 1;
    localparam int unsigned ERR_W      = 2;

    // Channel tag width; a single channel still gets a 1-bit tag.
    function automatic int unsigned ch_w(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_chan.sv
// One monitored serial line: synchroniser, frame decoder and a one-deep holding register.
module uart_rx_chan
    import uart_rx_monitor_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 gnt,
    output logic                 hold_valid,
    output logic [DATA_BITS-1:0] hold_data,
    output logic [ERR_W-1:0]     hold_err,
    output logic                 overflow
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = 3;

    logic [1:0]           sync;
    logic                 rx_s;
    logic                 tick;
    rx_state_e            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_err, par_err_n;
    logic                 frm_err, frm_err_n;
    logic                 hold_valid_n;
    logic [DATA_BITS-1:0] hold_data_n;
    logic [ERR_W-1:0]     hold_err_n;
    logic                 overflow_n;

    assign rx_s = sync[1];
    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= 2'b11;
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_err    <= 1'b0;
            frm_err    <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_err   <= '0;
            overflow   <= 1'b0;
        end else begin
            sync       <= {sync[0], rx};
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            par_err    <= par_err_n;
            frm_err    <= frm_err_n;
            hold_valid <= hold_valid_n;
            hold_data  <= hold_data_n;
            hold_err   <= hold_err_n;
            overflow   <= overflow_n;
        end
    end

    // Every sample is taken when the bit counter reaches zero, i.e. at mid-bit.
    always_comb begin
        state_n      = state;
        cnt_n        = tick ? cnt : cnt - 1'b1;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        par_err_n    = par_err;
        frm_err_n    = frm_err;
        hold_valid_n = hold_valid & ~gnt;
        hold_data_n  = hold_data;
        hold_err_n   = hold_err;
        overflow_n   = overflow;

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = CNT_W'(CLKS_PER_BIT / 2 - 1);
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n     = CNT_W'(CLKS_PER_BIT - 1);
                        bit_idx_n = '0;
                        par_err_n = 1'b0;
                        frm_err_n = 1'b0;
                        state_n   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    cnt_n     = CNT_W'(CLKS_PER_BIT - 1);
                    par_err_n = (((^shreg) ^ rx_s) != (PARITY == PAR_ODD));
                    state_n   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    cnt_n = CNT_W'(CLKS_PER_BIT - 1);
                    if (!rx_s) begin
                        frm_err_n = 1'b1;
                    end
                    if (bit_idx == BIT_W'(STOP_BITS - 1)) begin
                        state_n = ST_IDLE;
                        // A holding register being granted this cycle is free for the new frame.
                        if (hold_valid && !gnt) begin
                            overflow_n = 1'b1;
                        end else begin
                            hold_valid_n           = 1'b1;
                            hold_data_n            = shreg;
                            hold_err_n[ERR_FRAME]  = frm_err | ~rx_s;
                            hold_err_n[ERR_PARITY] = par_err;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// Multi-channel UART receive monitor: per-channel decoders, round-robin merge, shared FWFT FIFO.
module uart_rx_monitor
    import uart_rx_monitor_pkg::*;
#(
    parameter int unsigned CHANNELS     = 1,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           rx_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_BITS-1:0]          out_data_o,
    output logic [ch_w(CHANNELS)-1:0]     out_chan_o,
    output logic [ERR_W-1:0]              out_err_o,
    output logic [CHANNELS-1:0]           overflow_o
);

    localparam int unsigned CH_W    = ch_w(CHANNELS);
    localparam int unsigned ENTRY_W = CH_W + ERR_W + DATA_BITS;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    logic [CHANNELS-1:0]  hold_valid;
    logic [DATA_BITS-1:0] hold_data [CHANNELS];
    logic [ERR_W-1:0]     hold_err  [CHANNELS];
    logic [CHANNELS-1:0]  gnt;

    logic [CH_W-1:0]      rr_ptr, rr_ptr_nxt, gnt_idx, cand;
    logic                 gnt_any, push, pop, full, head_free, head_load;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        uart_rx_chan #(
            .CLKS_PER_BIT (CLKS_PER_BIT),
            .DATA_BITS    (DATA_BITS),
            .PARITY       (PARITY),
            .STOP_BITS    (STOP_BITS)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .rx         (rx_i[c]),
            .gnt        (gnt[c]),
            .hold_valid (hold_valid[c]),
            .hold_data  (hold_data[c]),
            .hold_err   (hold_err[c]),
            .overflow   (overflow_o[c])
        );
    end

    // Round-robin search starting at rr_ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cand = CH_W'((32'(rr_ptr) + i) % CHANNELS);
            if (!gnt_any && hold_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // The output register counts as one FIFO slot; storage holds the rest.
    assign pop        = out_valid_o & out_ready_i;
    assign full       = (fifo_cnt + CNT_W'(out_valid_o)) == CNT_W'(FIFO_DEPTH);
    assign push       = gnt_any & (~full | pop);
    assign head_free  = ~out_valid_o | pop;
    assign head_load  = head_free & (fifo_cnt != '0);
    assign push_entry = {gnt_idx, hold_err[gnt_idx], hold_data[gnt_idx]};
    assign rr_ptr_nxt = (gnt_idx == CH_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        gnt = '0;
        if (push) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_chan_o  <= '0;
            out_err_o   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= rr_ptr_nxt;
            end
            if (head_load) begin
                {out_chan_o, out_err_o, out_data_o} <= mem[rd_ptr];
                out_valid_o <= 1'b1;
                rd_ptr      <= rd_ptr + 1'b1;
            end else if (pop) begin
                out_valid_o <= 1'b0;
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(head_load);
        end
    end

endmodule
